// File: rtl/toggle_counter_reg.sv
// Multi-bit toggle register / up-down counter with programmable terminal count.
// Modes 0-2 count with a wrap/saturate/reload policy; mode 3 is a per-bit toggle register.
module toggle_counter_reg #(
   parameter int unsigned width       = 8,
   parameter int unsigned maxVal      = 255,
   parameter int unsigned mode        = 0,
   parameter bit          invertClock = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             preset,
   input  logic             load,
   input  logic [width-1:0] loadData,
   input  logic             up,
   input  logic [width-1:0] t,
   input  logic             tick,
   output logic [width-1:0] q,
   output logic [width-1:0] qBar,
   output logic             carryOut,
   output logic             zero
);

   localparam int unsigned W     = width;
   localparam logic [W-1:0] MAX_V = W'(maxVal);
   localparam logic [W-1:0] ONES  = '1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W-1:0] next_c;

   // Ticked next state, including the terminal-count action for the chosen mode
   always_comb begin
      next_c = count_q;
      if (mode == 3) begin
         next_c = count_q ^ t;
      end else if (up) begin
         if (count_q < MAX_V) begin
            next_c = count_q + W'(1);
         end else begin
            case (mode)
               0:       next_c = '0;
               2:       next_c = loadData;
               default: next_c = count_q;
            endcase
         end
      end else if (count_q == '0) begin
         case (mode)
            0:       next_c = MAX_V;
            2:       next_c = loadData;
            default: next_c = count_q;
         endcase
      end else begin
         // Values above the terminal count (only reachable by load) still step down
         next_c = count_q - W'(1);
      end
   end

   // Control priority below reset: preset, then load, then tick
   always_comb begin
      count_d = count_q;
      if (preset) begin
         count_d = (mode == 3) ? ONES : MAX_V;
      end else if (load) begin
         count_d = loadData;
      end else if (tick) begin
         count_d = next_c;
      end
   end

   // Active edge is fixed at elaboration; only one of these branches exists
   generate
      if (invertClock) begin : g_negedge
         always_ff @(negedge clock) begin
            if (reset) count_q <= '0;
            else       count_q <= count_d;
         end
      end else begin : g_posedge
         always_ff @(posedge clock) begin
            if (reset) count_q <= '0;
            else       count_q <= count_d;
         end
      end
   endgenerate

   // Terminal strobe coincides with the edge that performs the terminal action
   always_comb begin
      carryOut = 1'b0;
      if (mode == 3) begin
         carryOut = tick & ((count_q ^ t) == '0);
      end else if (up) begin
         carryOut = tick & (count_q >= MAX_V);
      end else begin
         carryOut = tick & (count_q == '0);
      end
   end

   assign q    = count_q;
   assign qBar = ~count_q;
   assign zero = (count_q == '0);

endmodule
